// File: rtl/conv_pool_flatten.sv
// 2x2/stride-2 max-pooling of both layer-0 kernel maps into the layer-1 maps,
// and the interleaved layer-2 flatten memory, written in one pass over the shared bus.
module conv_pool_flatten #(
    parameter int         DATA_W    = 20,
    parameter int         ADDR_W    = 12,
    parameter int         IN_W      = 64,
    parameter logic [2:0] CSEL_L0K0 = 3'b001,
    parameter logic [2:0] CSEL_L0K1 = 3'b010,
    parameter logic [2:0] CSEL_L1K0 = 3'b011,
    parameter logic [2:0] CSEL_L1K1 = 3'b100,
    parameter logic [2:0] CSEL_L2   = 3'b101
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DATA_W-1:0] cdata_wr,
    output logic [2:0]        csel
);

    localparam int HALF = IN_W / 2;
    localparam int HW   = $clog2(HALF);
    localparam int LW   = $clog2(IN_W);
    localparam logic [HW-1:0] LAST = HW'(HALF - 1);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR_L1, WR_L2, DONE} state_t;

    state_t                     state, state_n;
    logic [HW-1:0]              r, r_n, c, c_n;
    logic                       k, k_n;
    logic [1:0]                 q, q_n;
    logic signed [DATA_W-1:0]   max_val, max_n;
    logic signed [DATA_W-1:0]   rd_s;
    logic                       busy_n, done_n, crd_n, cwr_n;
    logic [ADDR_W-1:0]          caddr_rd_n, caddr_wr_n;
    logic [DATA_W-1:0]          cdata_wr_n;
    logic [2:0]                 csel_n;

    assign rd_s = cdata_rd;

    // Tap q of output pixel (rr,cc): row 2rr+q[1], column 2cc+q[0].
    function automatic logic [ADDR_W-1:0] tap_addr(input logic [HW-1:0] rr,
                                                   input logic [HW-1:0] cc,
                                                   input logic [1:0]    qq);
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        row = ADDR_W'({rr, qq[1]});
        col = ADDR_W'({cc, qq[0]});
        return (row << LW) | col;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            r        <= '0;
            c        <= '0;
            k        <= 1'b0;
            q        <= '0;
            max_val  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            csel     <= 3'b000;
        end else begin
            state    <= state_n;
            r        <= r_n;
            c        <= c_n;
            k        <= k_n;
            q        <= q_n;
            max_val  <= max_n;
            busy     <= busy_n;
            done     <= done_n;
            crd      <= crd_n;
            cwr      <= cwr_n;
            caddr_rd <= caddr_rd_n;
            caddr_wr <= caddr_wr_n;
            cdata_wr <= cdata_wr_n;
            csel     <= csel_n;
        end
    end

    // Outputs are computed for the next state so every strobe comes straight from a flop.
    always_comb begin
        state_n    = state;
        r_n        = r;
        c_n        = c;
        k_n        = k;
        q_n        = q;
        max_n      = max_val;
        busy_n     = busy;
        done_n     = 1'b0;
        crd_n      = 1'b0;
        cwr_n      = 1'b0;
        csel_n     = 3'b000;
        caddr_rd_n = caddr_rd;
        caddr_wr_n = caddr_wr;
        cdata_wr_n = cdata_wr;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RD;
                    busy_n  = 1'b1;
                    q_n     = 2'd0;
                    crd_n   = 1'b1;
                end
            end
            RD: begin
                // Read data trails the strobe by one cycle, so tap q-1 arrives now.
                if (q == 2'd1) begin
                    max_n = rd_s;
                end else if (q != 2'd0 && rd_s > max_val) begin
                    max_n = rd_s;
                end
                if (q == 2'd3) begin
                    state_n = CAP;
                    q_n     = 2'd0;
                end else begin
                    q_n   = q + 2'd1;
                    crd_n = 1'b1;
                end
            end
            CAP: begin
                if (rd_s > max_val) begin
                    max_n = rd_s;
                end
                state_n    = WR_L1;
                cwr_n      = 1'b1;
                csel_n     = k ? CSEL_L1K1 : CSEL_L1K0;
                caddr_wr_n = ADDR_W'({r, c});
                cdata_wr_n = max_n;
            end
            WR_L1: begin
                state_n    = WR_L2;
                cwr_n      = 1'b1;
                csel_n     = CSEL_L2;
                caddr_wr_n = ADDR_W'({r, c, k});
            end
            WR_L2: begin
                if (!k) begin
                    k_n     = 1'b1;
                    state_n = RD;
                    crd_n   = 1'b1;
                end else begin
                    k_n = 1'b0;
                    c_n = c + HW'(1);
                    if (c == LAST) begin
                        r_n = r + HW'(1);
                    end
                    if (c == LAST && r == LAST) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = RD;
                        crd_n   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (crd_n) begin
            csel_n     = k_n ? CSEL_L0K1 : CSEL_L0K0;
            caddr_rd_n = tap_addr(r_n, c_n, q_n);
        end
    end

endmodule

// File: tb/tb_conv_pool_flatten.sv
// Self-checking bench for conv_pool_flatten: memory models on the shared bus,
// a reference pooling model, directed corner values and a reset-mid-pass scenario.
module tb_conv_pool_flatten;

    localparam int DATA_W   = 20;
    localparam int ADDR_W   = 12;
    localparam int IN_W     = 64;
    localparam int NPIX     = 1024;
    localparam int PASS_CYC = 14336;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy, done, crd, cwr;
    logic [ADDR_W-1:0] caddr_rd, caddr_wr;
    logic [DATA_W-1:0] cdata_rd = '0;
    logic [DATA_W-1:0] cdata_wr;
    logic [2:0]        csel;

    logic [DATA_W-1:0] l0k0 [4096];
    logic [DATA_W-1:0] l0k1 [4096];
    logic [DATA_W-1:0] l1k0 [1024];
    logic [DATA_W-1:0] l1k1 [1024];
    logic [DATA_W-1:0] l2   [2048];

    int n_cmp     = 0;
    int n_bad     = 0;
    int proto_err = 0;

    always #5 clk = ~clk;

    conv_pool_flatten dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    // Synchronous memories: read data one cycle after crd, writes commit at the cwr edge.
    always @(posedge clk) begin
        if (crd) begin
            case (csel)
                3'b001:  cdata_rd <= l0k0[caddr_rd];
                3'b010:  cdata_rd <= l0k1[caddr_rd];
                default: cdata_rd <= '0;
            endcase
        end
        if (cwr) begin
            case (csel)
                3'b011:  l1k0[caddr_wr[9:0]]  = cdata_wr;
                3'b100:  l1k1[caddr_wr[9:0]]  = cdata_wr;
                3'b101:  l2[caddr_wr[10:0]]   = cdata_wr;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (crd && cwr) proto_err++;
            if ((crd || cwr) && csel == 3'b000) proto_err++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed maximum of the four taps of pixel p, straight from the pooling rule.
    function automatic logic [DATA_W-1:0] model_max(input int kk, input int p);
        int pr, pc, best, v;
        logic [11:0] a;
        logic [DATA_W-1:0] w;
        pr = p / 32;
        pc = p % 32;
        best = 0;
        for (int t = 0; t < 4; t++) begin
            a = 12'((2 * pr + t / 2) * IN_W + 2 * pc + t % 2);
            w = (kk == 1) ? l0k1[a] : l0k0[a];
            v = int'($signed(w));
            if (t == 0 || v > best) best = v;
        end
        return DATA_W'(best);
    endfunction

    // Runs one pass from a start pulse, optionally pulsing start again mid-pass.
    task automatic applyStimulus(input int inject_at, output int busy_cyc, output int done_idx,
                                 output int first_wr, output int last_l2, output int done_cnt);
        int cyc, after;
        busy_cyc = 0; done_idx = -1; first_wr = -1; last_l2 = -1; done_cnt = 0; after = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < PASS_CYC + 100 && after < 4) begin
            if (busy) busy_cyc++;
            if (cwr && first_wr < 0) first_wr = cyc;
            if (cwr && csel == 3'b101 && caddr_wr == 12'd2047) last_l2 = cyc;
            if (done) begin
                done_cnt++;
                done_idx = cyc;
            end
            if (done_idx >= 0) after++;
            start = (cyc == inject_at);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic checkPass(input string tag, input int busy_cyc, input int done_idx,
                             input int first_wr, input int last_l2, input int done_cnt);
        checkOutput({tag, " first write latency"}, first_wr - 1, 5);
        checkOutput({tag, " busy cycles"}, busy_cyc, PASS_CYC);
        checkOutput({tag, " pass length"}, done_idx, PASS_CYC + 1);
        checkOutput({tag, " done after last L2"}, done_idx - last_l2, 1);
        checkOutput({tag, " done pulse count"}, done_cnt, 1);
        checkOutput({tag, " idle busy"}, busy, 0);
        checkOutput({tag, " idle csel"}, csel, 0);
    endtask

    initial begin
        int busy_cyc, done_idx, first_wr, last_l2, done_cnt, cnt, cyc, bad0, bad1, bad2;
        int pr, pc, e0, e1;
        logic [DATA_W-1:0] exp0 [1024];
        logic [DATA_W-1:0] exp1 [1024];

        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            if (i % 3 == 0) begin
                l0k0[12'(i)] = DATA_W'($urandom_range(0, 3));
                l0k1[12'(i)] = DATA_W'($urandom_range(0, 3));
            end else begin
                l0k0[12'(i)] = DATA_W'($urandom);
                l0k1[12'(i)] = DATA_W'($urandom);
            end
        end
        l0k0[0] = 20'd5;  l0k0[1] = 20'd9;  l0k0[64] = 20'd3;  l0k0[65] = 20'd9;
        l0k1[0] = 20'd0;  l0k1[1] = 20'd0;  l0k1[64] = 20'd0;  l0k1[65] = 20'd0;
        l0k0[2] = 20'hFFFFD; l0k0[3] = 20'hFFFF9; l0k0[66] = 20'hFFFFF; l0k0[67] = 20'hFFFFE;
        l0k1[4030] = 20'd1; l0k1[4031] = 20'd2; l0k1[4094] = 20'd3; l0k1[4095] = 20'd4;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset crd", crd, 0);
        checkOutput("reset cwr", cwr, 0);
        checkOutput("reset csel", csel, 0);
        checkOutput("reset caddr_rd", caddr_rd, 0);
        checkOutput("reset caddr_wr", caddr_wr, 0);
        checkOutput("reset cdata_wr", cdata_wr, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle without start", busy, 0);

        for (int p = 0; p < NPIX; p++) begin
            exp0[10'(p)] = model_max(0, p);
            exp1[10'(p)] = model_max(1, p);
        end

        $display("[TB] random pass with a start pulse while busy");
        applyStimulus(100, busy_cyc, done_idx, first_wr, last_l2, done_cnt);
        checkPass("random", busy_cyc, done_idx, first_wr, last_l2, done_cnt);
        checkOutput("L1K0[0] block", l1k0[0], 20'd9);
        checkOutput("L2[0] block", l2[0], 20'd9);
        checkOutput("L1K1[0] zeros", l1k1[0], 20'd0);
        checkOutput("L2[1] zeros", l2[1], 20'd0);
        checkOutput("L1K0[1] signed", l1k0[1], 20'hFFFFF);
        checkOutput("L2[2] signed", l2[2], 20'hFFFFF);
        checkOutput("L1K1[1023] last", l1k1[1023], 20'd4);
        checkOutput("L2[2047] last", l2[2047], 20'd4);
        bad0 = 0; bad1 = 0; bad2 = 0;
        for (int p = 0; p < NPIX; p++) begin
            if (l1k0[10'(p)] !== exp0[10'(p)]) bad0++;
            if (l1k1[10'(p)] !== exp1[10'(p)]) bad1++;
            if (l2[11'(2 * p)] !== exp0[10'(p)] || l2[11'(2 * p + 1)] !== exp1[10'(p)]) bad2++;
        end
        checkOutput("random L1K0 bad entries", bad0, 0);
        checkOutput("random L1K1 bad entries", bad1, 0);
        checkOutput("random L2 bad entries", bad2, 0);

        $display("[TB] ramp data, reset during the 500th layer-1 write");
        for (int i = 0; i < 4096; i++) begin
            l0k0[12'(i)] = DATA_W'(i);
            l0k1[12'(i)] = DATA_W'(4095 - i);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        cyc = 0;
        while (cnt < 500 && cyc < 10000) begin
            if (cwr && (csel == 3'b011 || csel == 3'b100)) begin
                cnt++;
                if (cnt == 500) break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("reached 500th WR_L1", cnt, 500);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("mid-pass reset busy", busy, 0);
        checkOutput("mid-pass reset cwr", cwr, 0);
        checkOutput("mid-pass reset crd", crd, 0);
        checkOutput("mid-pass reset csel", csel, 0);
        @(posedge clk); #1;
        checkOutput("stays idle after reset", busy, 0);

        for (int i = 0; i < 1024; i++) begin
            l1k0[10'(i)] = 20'hABCDE;
            l1k1[10'(i)] = 20'hABCDE;
        end
        for (int i = 0; i < 2048; i++) l2[11'(i)] = 20'hABCDE;

        applyStimulus(-1, busy_cyc, done_idx, first_wr, last_l2, done_cnt);
        checkPass("ramp", busy_cyc, done_idx, first_wr, last_l2, done_cnt);
        bad0 = 0; bad1 = 0; bad2 = 0;
        for (int p = 0; p < NPIX; p++) begin
            pr = p / 32;
            pc = p % 32;
            e0 = (2 * pr + 1) * 64 + 2 * pc + 1;
            e1 = 4095 - (2 * pr) * 64 - 2 * pc;
            if (l1k0[10'(p)] !== DATA_W'(e0)) bad0++;
            if (l1k1[10'(p)] !== DATA_W'(e1)) bad1++;
            if (l2[11'(2 * p)] !== DATA_W'(e0) || l2[11'(2 * p + 1)] !== DATA_W'(e1)) bad2++;
        end
        checkOutput("ramp L1K0 bad entries", bad0, 0);
        checkOutput("ramp L1K1 bad entries", bad1, 0);
        checkOutput("ramp L2 bad entries", bad2, 0);
        checkOutput("ramp L1K0[1023]", l1k0[1023], 20'd4095);
        checkOutput("ramp L1K1[0]", l1k1[0], 20'd4095);

        checkOutput("bus protocol violations", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
